// File: rtl/bcd_counter_display.sv
// bcd_counter_display
//   N-digit BCD up/down counter with tick prescaler, digit scan multiplexer,
//   7-segment decoder and leading-zero blanking, driving a 7-segment bank.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits / anodes (1..8)
//   TICK_DIV    clk cycles per count tick (>= 2)
//   SCAN_DIV    clk cycles per scan slot (>= 2)
//   ACTIVE_LOW  1 = seg/AN active-low, 0 = active-high
//
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   en        count enable (gates the prescaler)
//   up_dn     1 = up, 0 = down
//   clear     synchronous clear of the count
//   load      synchronous load of load_val (nibbles > 9 clamp to 9)
//   load_val  BCD load value, digit i in [4i+3:4i]
//   blank_lz  blank leading zero digits
//   value     current BCD count
//   tick      one-cycle strobe when the count advances
//   tc        one-cycle terminal-count pulse on a tick-driven wrap
//   seg       segments, seg[0]=a .. seg[6]=g
//   AN        digit anodes
module bcd_counter_display #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    blank_lz,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    tick,
    output logic                    tc,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             presc;
    logic [SW-1:0]             scan_cnt;
    logic [IW-1:0]             scan_idx;
    logic [4*NUM_DIGITS-1:0]   next_val;
    logic [4*NUM_DIGITS-1:0]   load_cl;
    logic                      wrap;
    logic                      carry;
    logic [3:0]                d;
    logic                      zero_above;
    logic [NUM_DIGITS-1:0]     blank;
    logic [3:0]                cur;
    logic                      blank_cur;
    logic [6:0]                seg_log;
    logic [NUM_DIGITS-1:0]     an_log;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick = en && (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
        end
    end

    // Ripple carry/borrow: a digit moves only while every lower digit wrapped.
    always_comb begin
        next_val = value;
        carry    = 1'b1;
        d        = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d = value[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (d == 4'd9) begin
                        next_val[4*i +: 4] = 4'd0;
                    end else begin
                        next_val[4*i +: 4] = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        next_val[4*i +: 4] = 4'd9;
                    end else begin
                        next_val[4*i +: 4] = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end

    always_comb begin
        load_cl = load_val;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_cl[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                value <= '0;
            end else if (load) begin
                value <= load_cl;
            end else if (tick) begin
                value <= next_val;
                tc    <= wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Walk from the top digit down so zero_above means "this digit and all
    // higher digits are zero"; digit 0 is always shown.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_above = zero_above & (value[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-i] = blank_lz & zero_above & (i != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        cur       = '0;
        blank_cur = 1'b0;
        an_log    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur       = value[4*i +: 4];
                blank_cur = blank[i];
            end
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_log[i] = (scan_idx == IW'(i)) & ~blank_cur;
        end
        seg_log = blank_cur ? 7'b0000000 : decode(cur);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg <= ACTIVE_LOW ? '1 : '0;
            AN  <= ACTIVE_LOW ? '1 : '0;
        end else begin
            seg <= ACTIVE_LOW ? ~seg_log : seg_log;
            AN  <= ACTIVE_LOW ? ~an_log : an_log;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display
//   Directed bench for bcd_counter_display with NUM_DIGITS=4, TICK_DIV=4,
//   SCAN_DIV=2, ACTIVE_LOW=1. Inputs change and outputs are sampled around
//   the falling clock edge.
module tb_bcd_counter_display;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          up_dn;
    logic          clear;
    logic          load;
    logic [15:0]   load_val;
    logic          blank_lz;
    logic [15:0]   value;
    logic          tick;
    logic          tc;
    logic [6:0]    seg;
    logic [3:0]    AN;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_4   = 7'b0011001;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .NUM_DIGITS(ND),
        .TICK_DIV(TD),
        .SCAN_DIV(SD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .up_dn(up_dn),
        .clear(clear),
        .load(load),
        .load_val(load_val),
        .blank_lz(blank_lz),
        .value(value),
        .tick(tick),
        .tc(tc),
        .seg(seg),
        .AN(AN)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Enables counting and returns with en still high in the cycle where
    // tick is visible; found=0 if none shows within the bound.
    task automatic wait_tick_visible(output bit found);
        found = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 2 * TD; i++) begin
            #1;
            if (tick) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Lets exactly one tick be consumed, then stops the prescaler.
    task automatic wait_one_tick(output bit found);
        wait_tick_visible(found);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h exp=%h", value, 16'h0000); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (AN !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", AN); end
        checks++; if (seg !== SEG_OFF) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg, SEG_OFF); end
        rstn = 1'b1;
        #1;
        checks++; if (AN !== 4'b1111) begin failures++; $display("FAIL release_an_pre got=%b exp=1111", AN); end
        @(negedge clk);
        checks++; if (AN !== 4'b1110) begin failures++; $display("FAIL release_an got=%b exp=1110", AN); end
        checks++; if (seg !== SEG_0) begin failures++; $display("FAIL release_seg got=%b exp=%b", seg, SEG_0); end
    endtask

    // Prescaler is at 0 after reset with en low, so the tick phase is known.
    task automatic test_up_wrap;
        logic exp_tick;
        do_load(16'h9998);
        checks++; if (value !== 16'h9998) begin failures++; $display("FAIL up_load got=%h exp=9998", value); end
        up_dn = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_tick = ((k % 4) == 3);
            checks++; if (tick !== exp_tick) begin failures++; $display("FAIL up_tick_cycle%0d got=%b exp=%b", k, tick, exp_tick); end
            if (k == 4) begin
                checks++; if (value !== 16'h9999) begin failures++; $display("FAIL up_first got=%h exp=9999", value); end
                checks++; if (tc !== 1'b0) begin failures++; $display("FAIL up_first_tc got=%b exp=0", tc); end
            end
            if (k == 8) begin
                checks++; if (value !== 16'h0000) begin failures++; $display("FAIL up_wrap got=%h exp=0000", value); end
                checks++; if (tc !== 1'b1) begin failures++; $display("FAIL up_wrap_tc got=%b exp=1", tc); end
            end
            if (k == 9) begin
                checks++; if (tc !== 1'b0) begin failures++; $display("FAIL up_tc_width got=%b exp=0", tc); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_clamp;
        do_load(16'hA3F2);
        checks++; if (value !== 16'h9392) begin failures++; $display("FAIL load_clamp got=%h exp=9392", value); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL load_clamp_tc got=%b exp=0", tc); end
    endtask

    task automatic test_down;
        bit found;
        up_dn = 1'b0;
        do_load(16'h0100);
        wait_one_tick(found);
        checks++; if (!found) begin failures++; $display("FAIL down_tick_timeout got=none exp=tick"); end
        checks++; if (value !== 16'h0099) begin failures++; $display("FAIL down_borrow got=%h exp=0099", value); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL down_borrow_tc got=%b exp=0", tc); end
        do_load(16'h0000);
        wait_one_tick(found);
        checks++; if (!found) begin failures++; $display("FAIL down_wrap_timeout got=none exp=tick"); end
        checks++; if (value !== 16'h9999) begin failures++; $display("FAIL down_wrap got=%h exp=9999", value); end
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL down_wrap_tc got=%b exp=1", tc); end
        @(negedge clk);
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL down_tc_width got=%b exp=0", tc); end
        checks++; if (value !== 16'h9999) begin failures++; $display("FAIL down_hold got=%h exp=9999", value); end
    endtask

    // Each tick here would wrap (9999 up, 0000 down) and raise tc if it won.
    task automatic test_priority;
        bit found;
        up_dn = 1'b1;
        wait_tick_visible(found);
        checks++; if (!found) begin failures++; $display("FAIL prio_clear_timeout got=none exp=tick"); end
        clear = 1'b1; load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; en = 1'b0;
        checks++; if (value !== 16'h0000) begin failures++; $display("FAIL prio_clear got=%h exp=0000", value); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL prio_clear_tc got=%b exp=0", tc); end
        up_dn = 1'b0;
        wait_tick_visible(found);
        checks++; if (!found) begin failures++; $display("FAIL prio_load_timeout got=none exp=tick"); end
        load = 1'b1; load_val = 16'h0042;
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        checks++; if (value !== 16'h0042) begin failures++; $display("FAIL prio_load got=%h exp=0042", value); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL prio_load_tc got=%b exp=0", tc); end
    endtask

    task automatic test_blanking;
        int n0, n1, nb, bad;
        blank_lz = 1'b1;
        @(negedge clk);
        n0 = 0; n1 = 0; nb = 0; bad = 0;
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk);
            case (AN)
                4'b1110: begin
                    n0++;
                    checks++; if (seg !== SEG_2) begin failures++; $display("FAIL blank_d0_seg got=%b exp=%b", seg, SEG_2); end
                end
                4'b1101: begin
                    n1++;
                    checks++; if (seg !== SEG_4) begin failures++; $display("FAIL blank_d1_seg got=%b exp=%b", seg, SEG_4); end
                end
                4'b1111: begin
                    nb++;
                    checks++; if (seg !== SEG_OFF) begin failures++; $display("FAIL blank_off_seg got=%b exp=%b", seg, SEG_OFF); end
                end
                default: bad++;
            endcase
        end
        checks++; if (n0 !== 2) begin failures++; $display("FAIL blank_d0_slots got=%0d exp=2", n0); end
        checks++; if (n1 !== 2) begin failures++; $display("FAIL blank_d1_slots got=%0d exp=2", n1); end
        checks++; if (nb !== 4) begin failures++; $display("FAIL blank_dark_slots got=%0d exp=4", nb); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL blank_upper_lit got=%0d exp=0", bad); end

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        n0 = 0; nb = 0; bad = 0;
        for (int k = 0; k < ND * SD; k++) begin
            @(negedge clk);
            if (AN === 4'b1110) begin
                n0++;
                checks++; if (seg !== SEG_0) begin failures++; $display("FAIL zero_d0_seg got=%b exp=%b", seg, SEG_0); end
            end else if (AN === 4'b1111) begin
                nb++;
            end else begin
                bad++;
            end
        end
        checks++; if (n0 !== 2) begin failures++; $display("FAIL zero_d0_slots got=%0d exp=2", n0); end
        checks++; if (nb !== 6) begin failures++; $display("FAIL zero_dark_slots got=%0d exp=6", nb); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL zero_upper_lit got=%0d exp=0", bad); end
        blank_lz = 1'b0;
    endtask

    task automatic test_enable_hold;
        bit found;
        logic [3:0] prev;
        int trans;
        up_dn = 1'b1;
        do_load(16'h0005);
        wait_one_tick(found);
        checks++; if (!found) begin failures++; $display("FAIL hold_tick_timeout got=none exp=tick"); end
        checks++; if (value !== 16'h0006) begin failures++; $display("FAIL hold_pre got=%h exp=0006", value); end
        // Prescaler is 0 here; run it to 2 and freeze it.
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL hold_pre_tick got=%b exp=0", tick); end
        en = 1'b0;
        prev = AN;
        trans = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if (value !== 16'h0006) begin failures++; $display("FAIL hold_value got=%h exp=0006", value); end
            checks++; if (tick !== 1'b0) begin failures++; $display("FAIL hold_tick got=%b exp=0", tick); end
            if (AN !== prev) trans++;
            prev = AN;
        end
        checks++; if (trans !== 10) begin failures++; $display("FAIL hold_scan got=%0d exp=10", trans); end
        en = 1'b1;
        #1;
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL resume_tick_early got=%b exp=0", tick); end
        @(negedge clk);
        #1;
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", tick); end
        @(negedge clk);
        en = 1'b0;
        checks++; if (value !== 16'h0007) begin failures++; $display("FAIL resume_value got=%h exp=0007", value); end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_clamp;
        test_down;
        test_priority;
        test_blanking;
        test_enable_hold;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
